// File: rtl/rc_col_pkg.sv
// Shared constants, FSM state type and beat-count helper for the column
// insert (write-direction scatter) block.
package rc_col_pkg;

   localparam int BUS_BYTES  = 16;
   localparam int BUS_BITS   = 8 * BUS_BYTES;
   localparam int COL_BYTES  = 64;
   localparam int COL_BITS   = 8 * COL_BYTES;
   localparam int MAX_BEATS  = 5;
   localparam int STAGE_BITS = MAX_BEATS * BUS_BITS;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_e;

   // ceil((start + len) / BUS_BYTES); len is already clamped, so the sum fits in 7 bits
   function automatic logic [2:0] beats_needed(input logic [3:0] start, input logic [6:0] len);
      logic [6:0] sum;
      sum = {3'b000, start} + len;
      return 3'((sum + 7'd15) >> 4);
   endfunction

endpackage

// File: rtl/ins_col_if.sv
// Request/write-channel bundle for ins_col: packed column request in,
// strobed bus beats out.
interface ins_col_if;
   import rc_col_pkg::*;

   logic                 i_valid;
   logic                 o_ready;
   logic [COL_BITS-1:0]  i_col_data;
   logic [3:0]           i_start;
   logic [6:0]           i_len;
   logic                 o_valid;
   logic                 i_ready;
   logic [BUS_BITS-1:0]  o_w_data;
   logic [BUS_BYTES-1:0] o_w_strb;
   logic                 o_w_last;
   logic                 o_done;

   modport master (
      output i_valid, i_col_data, i_start, i_len, i_ready,
      input  o_ready, o_valid, o_w_data, o_w_strb, o_w_last, o_done
   );

   modport slave (
      input  i_valid, i_col_data, i_start, i_len, i_ready,
      output o_ready, o_valid, o_w_data, o_w_strb, o_w_last, o_done
   );

endinterface

// File: rtl/ins_col_slice.sv
// Picks one bus beat out of the staging vector and masks it to the bytes
// that actually belong to the column.
module ins_col_slice
   import rc_col_pkg::*;
(
   input  logic [STAGE_BITS-1:0] stage,
   input  logic [2:0]            beat,
   input  logic [3:0]            start,
   input  logic [6:0]            len,
   output logic [BUS_BITS-1:0]   data,
   output logic [BUS_BYTES-1:0]  strb
);

   logic [BUS_BITS-1:0] beat_vec;
   logic [6:0]          col_end;
   logic [6:0]          pos;

   assign col_end = {3'b000, start} + len;

   always_comb begin
      beat_vec = '0;
      for (int i = 0; i < MAX_BEATS; i++) begin
         if (beat == 3'(i)) begin
            beat_vec = stage[STAGE_BITS-1-BUS_BITS*i -: BUS_BITS];
         end
      end
   end

   always_comb begin
      data = '0;
      strb = '0;
      pos  = '0;
      for (int k = 0; k < BUS_BYTES; k++) begin
         pos = {beat, 4'b0000} + 7'(k);
         if ((pos >= {3'b000, start}) && (pos < col_end)) begin
            data[BUS_BITS-1-8*k -: 8] = beat_vec[BUS_BITS-1-8*k -: 8];
            strb[BUS_BYTES-1-k]       = 1'b1;
         end
      end
   end

endmodule

// File: rtl/ins_col.sv
// Column insert: scatters one packed column into strobed bus beats starting
// at a byte offset, for write-back into row-layout memory.
//
// state | meaning
// IDLE  | ready for a request; zero-length requests answered with o_done
// SEND  | presenting beat beat_q of nb_q, advancing on each i_ready
module ins_col
   import rc_col_pkg::*;
(
   input  logic       i_clk,
   input  logic       i_rst_n,
   ins_col_if.slave   bus
);

   state_e               state_q, state_d;
   logic [2:0]           beat_q, beat_d;
   logic [2:0]           nb_q, nb_d;
   logic [3:0]           start_q, start_d;
   logic [6:0]           len_q, len_d;
   logic [STAGE_BITS-1:0] stage_q, stage_d;
   logic                 ready_q, ready_d;
   logic                 valid_q, valid_d;
   logic                 last_q, last_d;
   logic                 done_q, done_d;
   logic [BUS_BITS-1:0]  data_q, data_d;
   logic [BUS_BYTES-1:0] strb_q, strb_d;

   logic [6:0]            req_len;
   logic [2:0]            req_nb;
   logic [STAGE_BITS-1:0] req_stage;
   logic [2:0]            beat_nxt;

   logic [STAGE_BITS-1:0] sl_stage;
   logic [2:0]            sl_beat;
   logic [3:0]            sl_start;
   logic [6:0]            sl_len;
   logic [BUS_BITS-1:0]   sl_data;
   logic [BUS_BYTES-1:0]  sl_strb;

   assign req_len   = (bus.i_len > 7'(COL_BYTES)) ? 7'(COL_BYTES) : bus.i_len;
   assign req_nb    = beats_needed(bus.i_start, req_len);
   assign req_stage = {bus.i_col_data, {BUS_BITS{1'b0}}} >> {bus.i_start, 3'b000};
   assign beat_nxt  = beat_q + 3'd1;

   // One slice serves both the first beat (from the live request) and later beats (from the latched one).
   always_comb begin
      if (state_q == IDLE) begin
         sl_stage = req_stage;
         sl_beat  = 3'd0;
         sl_start = bus.i_start;
         sl_len   = req_len;
      end else begin
         sl_stage = stage_q;
         sl_beat  = beat_nxt;
         sl_start = start_q;
         sl_len   = len_q;
      end
   end

   ins_col_slice u_slice (
      .stage (sl_stage),
      .beat  (sl_beat),
      .start (sl_start),
      .len   (sl_len),
      .data  (sl_data),
      .strb  (sl_strb)
   );

   always_comb begin
      state_d = state_q;
      beat_d  = beat_q;
      nb_d    = nb_q;
      start_d = start_q;
      len_d   = len_q;
      stage_d = stage_q;
      ready_d = ready_q;
      valid_d = valid_q;
      last_d  = last_q;
      data_d  = data_q;
      strb_d  = strb_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.i_valid && ready_q) begin
               stage_d = req_stage;
               start_d = bus.i_start;
               len_d   = req_len;
               nb_d    = req_nb;
               if (req_len == 7'd0) begin
                  done_d = 1'b1;
               end else begin
                  state_d = SEND;
                  beat_d  = 3'd0;
                  ready_d = 1'b0;
                  valid_d = 1'b1;
                  data_d  = sl_data;
                  strb_d  = sl_strb;
                  last_d  = (req_nb == 3'd1);
               end
            end
         end
         SEND: begin
            if (bus.i_ready) begin
               if (beat_q == nb_q - 3'd1) begin
                  state_d = IDLE;
                  beat_d  = 3'd0;
                  ready_d = 1'b1;
                  valid_d = 1'b0;
                  done_d  = 1'b1;
                  data_d  = '0;
                  strb_d  = '0;
                  last_d  = 1'b0;
               end else begin
                  beat_d = beat_nxt;
                  data_d = sl_data;
                  strb_d = sl_strb;
                  last_d = (beat_nxt == nb_q - 3'd1);
               end
            end
         end
         default: begin
            state_d = IDLE;
            ready_d = 1'b1;
            valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q <= IDLE;
         beat_q  <= '0;
         nb_q    <= '0;
         start_q <= '0;
         len_q   <= '0;
         stage_q <= '0;
         ready_q <= 1'b1;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         done_q  <= 1'b0;
         data_q  <= '0;
         strb_q  <= '0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         nb_q    <= nb_d;
         start_q <= start_d;
         len_q   <= len_d;
         stage_q <= stage_d;
         ready_q <= ready_d;
         valid_q <= valid_d;
         last_q  <= last_d;
         done_q  <= done_d;
         data_q  <= data_d;
         strb_q  <= strb_d;
      end
   end

   assign bus.o_ready  = ready_q;
   assign bus.o_valid  = valid_q;
   assign bus.o_w_data = data_q;
   assign bus.o_w_strb = strb_q;
   assign bus.o_w_last = last_q;
   assign bus.o_done   = done_q;

endmodule

// File: tb/tb_ins_col.sv
// Scoreboard bench for ins_col: requests push expected beats built from the
// byte-placement rule; a negedge monitor pops and compares on each handshake.
module tb_ins_col;

   typedef struct {
      logic [127:0] data;
      logic [15:0]  strb;
      logic         last;
   } beat_t;

   logic clk;
   logic rst_n;
   ins_col_if bus();

   ins_col dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   beat_t exp_q[$];
   int    n_tests = 0;
   int    n_fail  = 0;
   int    hs_cnt  = 0;
   int    rdy_mode = 0;
   int    rdy_idx  = 0;

   logic         exp_done  = 1'b0;
   logic         check_rst = 1'b0;
   logic         stall_prev = 1'b0;
   logic [127:0] stall_data;
   logic [15:0]  stall_strb;
   logic         stall_last;

   function automatic void push_model(input logic [511:0] col, input int st, input int ln);
      int    l;
      int    nb;
      beat_t e;
      l = (ln > 64) ? 64 : ln;
      if (l == 0) return;
      nb = (st + l + 15) / 16;
      for (int b = 0; b < nb; b++) begin
         e.data = '0;
         e.strb = '0;
         for (int k = 0; k < 16; k++) begin
            int j;
            j = 16 * b + k - st;
            if (j >= 0 && j < l) begin
               e.data[127-8*k -: 8] = col[511-8*j -: 8];
               e.strb[15-k] = 1'b1;
            end
         end
         e.last = (b == nb - 1);
         exp_q.push_back(e);
      end
   endfunction

   always @(posedge clk) begin
      #1;
      case (rdy_mode)
         0: bus.i_ready = 1'b1;
         1: bus.i_ready = ((rdy_idx % 4) == 0) || ((rdy_idx % 4) == 3);
         default: bus.i_ready = ($urandom_range(0, 3) != 0);
      endcase
      rdy_idx++;
   end

   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
         exp_done   = 1'b0;
         check_rst  = 1'b1;
         stall_prev = 1'b0;
      end else begin
         if (check_rst) begin
            check_rst = 1'b0;
            n_tests++;
            if (bus.o_valid !== 1'b0 || bus.o_ready !== 1'b1 || bus.o_done !== 1'b0 ||
                bus.o_w_data !== '0 || bus.o_w_strb !== '0 || bus.o_w_last !== 1'b0) begin
               n_fail++;
               $display("FAIL reset_state: valid=%b ready=%b done=%b strb=%h last=%b, required 0 1 0 0000 0",
                        bus.o_valid, bus.o_ready, bus.o_done, bus.o_w_strb, bus.o_w_last);
            end
         end
         if (exp_done || bus.o_done) begin
            n_tests++;
            if (bus.o_done !== exp_done) begin
               n_fail++;
               $display("FAIL done_pulse: o_done=%b required %b", bus.o_done, exp_done);
            end
         end
         exp_done = 1'b0;
         if (stall_prev && bus.o_valid) begin
            n_tests++;
            if (bus.o_w_data !== stall_data || bus.o_w_strb !== stall_strb || bus.o_w_last !== stall_last) begin
               n_fail++;
               $display("FAIL stall_hold: data=%h strb=%h last=%b required %h %h %b",
                        bus.o_w_data, bus.o_w_strb, bus.o_w_last, stall_data, stall_strb, stall_last);
            end
         end
         stall_prev = 1'b0;
         if (bus.o_valid && !bus.i_ready) begin
            stall_prev = 1'b1;
            stall_data = bus.o_w_data;
            stall_strb = bus.o_w_strb;
            stall_last = bus.o_w_last;
         end
         if (bus.o_valid && bus.i_ready) begin
            beat_t e;
            hs_cnt++;
            n_tests++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL beat_unexpected: data=%h strb=%h, required no beat", bus.o_w_data, bus.o_w_strb);
            end else begin
               e = exp_q.pop_front();
               if (bus.o_w_data !== e.data || bus.o_w_strb !== e.strb || bus.o_w_last !== e.last) begin
                  n_fail++;
                  $display("FAIL beat: data=%h strb=%h last=%b required %h %h %b",
                           bus.o_w_data, bus.o_w_strb, bus.o_w_last, e.data, e.strb, e.last);
               end
            end
            if (bus.o_w_last) exp_done = 1'b1;
         end
         if (bus.i_valid && bus.o_ready && bus.i_len == 7'd0) exp_done = 1'b1;
      end
   end

   task automatic do_req(input logic [511:0] col, input int st, input int ln);
      int t;
      t = 0;
      @(posedge clk);
      #1;
      bus.i_valid    = 1'b1;
      bus.i_col_data = col;
      bus.i_start    = 4'(st);
      bus.i_len      = 7'(ln);
      forever begin
         @(negedge clk);
         if (bus.o_ready) begin
            push_model(col, st, ln);
            break;
         end
         t++;
         if (t > 300) begin
            n_tests++;
            n_fail++;
            $display("FAIL req_timeout: o_ready=%b required 1 within 300 cycles", bus.o_ready);
            break;
         end
      end
      @(posedge clk);
      #1;
      bus.i_valid = 1'b0;
   endtask

   function automatic logic [511:0] rand_col();
      logic [511:0] c;
      for (int i = 0; i < 16; i++) c[32*i +: 32] = $urandom;
      return c;
   endfunction

   initial begin
      logic [511:0] col;
      int hs0;
      int t;
      rst_n          = 1'b0;
      bus.i_valid    = 1'b0;
      bus.i_col_data = '0;
      bus.i_start    = '0;
      bus.i_len      = '0;
      bus.i_ready    = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (2) @(posedge clk);

      rdy_mode = 0;
      col = rand_col();
      for (int j = 0; j < 16; j++) col[511-8*j -: 8] = 8'(j);
      do_req(col, 0, 16);
      col = rand_col();
      col[511:480] = 32'hAABBCCDD;
      do_req(col, 5, 4);
      do_req(rand_col(), 12, 8);
      col = rand_col();
      do_req(col, 15, 64);
      do_req(rand_col(), 7, 0);

      rdy_mode = 1;
      do_req(col, 15, 100);
      do_req(rand_col(), 3, 37);

      rdy_mode = 0;
      repeat (10) @(posedge clk);
      do_req(rand_col(), 15, 64);
      hs0 = hs_cnt;
      t = 0;
      while (hs_cnt < hs0 + 2 && t < 50) begin
         @(posedge clk);
         t++;
      end
      #1 rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (4) @(posedge clk);
      do_req(rand_col(), 9, 20);

      rdy_mode = 2;
      for (int i = 0; i < 40; i++) begin
         int ln;
         ln = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 127);
         do_req(rand_col(), $urandom_range(0, 15), ln);
      end

      t = 0;
      while ((exp_q.size() != 0 || bus.o_valid) && t < 1000) begin
         @(posedge clk);
         t++;
      end
      repeat (3) @(posedge clk);
      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d beats outstanding, required 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
